// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FWFT FIFO controller over a one-cycle-latency dual-port SRAM.
// Optional sticky error flags are built when SRAM_FIFO_ERR_EN is defined.
module sram_fifo_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  input  logic                 cfg_load,
  input  logic [ADDR_SIZE:0]   cfg_depth,
  output logic [ADDR_SIZE:0]   depth,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
`ifdef SRAM_FIFO_ERR_EN
  output logic                 overflow_err,
  output logic                 underflow_err,
  output logic                 cfg_err,
`endif
  output logic                 write_enable,
  output logic [ADDR_SIZE-1:0] write_address,
  output logic [DATA_SIZE-1:0] write_data,
  output logic                 read_enable,
  output logic [ADDR_SIZE-1:0] read_address,
  input  logic [DATA_SIZE-1:0] read_data
);

  localparam logic [ADDR_SIZE:0]   MAX_DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0]   MIN_DEPTH = {{(ADDR_SIZE-1){1'b0}}, 2'b10};
  localparam logic [ADDR_SIZE-1:0] PTR_ONE   = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE:0]   CNT_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};

  logic [ADDR_SIZE:0]   ram_count;
  logic                 inflight;
  logic [1:0]           stage_count;
  logic [ADDR_SIZE-1:0] wptr, rptr;
  logic [DATA_SIZE-1:0] head, tail;
  logic                 push, pop, rd, cfg_ok;
  logic [ADDR_SIZE:0]   cfg_clamped;
  logic [ADDR_SIZE-1:0] wptr_next, rptr_next;

  assign count = ram_count + {{ADDR_SIZE{1'b0}}, inflight}
               + {{(ADDR_SIZE-1){1'b0}}, stage_count};
  assign in_ready = (count < depth);
  assign full     = (count == depth);
  assign empty    = (count == '0);

  // The word returning from the SRAM is presented directly while it is in flight,
  // which is what gives the two-cycle push-to-out_valid latency.
  assign out_valid = (stage_count != 2'd0) || inflight;
  assign out_data  = (stage_count != 2'd0) ? head : (inflight ? read_data : '0);

  assign push = rst_n && in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign rd   = (ram_count != '0) &&
                (({1'b0, stage_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign cfg_ok = cfg_load && (count == '0) && !push;

  assign write_enable  = push;
  assign write_address = push ? wptr : '0;
  assign write_data    = push ? in_data : '0;
  assign read_enable   = rd;
  assign read_address  = rd ? rptr : '0;

  assign wptr_next = ({1'b0, wptr} == depth - CNT_ONE) ? '0 : wptr + PTR_ONE;
  assign rptr_next = ({1'b0, rptr} == depth - CNT_ONE) ? '0 : rptr + PTR_ONE;

  always_comb begin
    cfg_clamped = cfg_depth;
    if (cfg_depth < MIN_DEPTH)
      cfg_clamped = MIN_DEPTH;
    else if (cfg_depth > MAX_DEPTH)
      cfg_clamped = MAX_DEPTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_count   <= '0;
      inflight    <= 1'b0;
      stage_count <= 2'd0;
      wptr        <= '0;
      rptr        <= '0;
      head        <= '0;
      tail        <= '0;
      depth       <= MAX_DEPTH;
    end else begin
      ram_count   <= ram_count + {{ADDR_SIZE{1'b0}}, push} - {{ADDR_SIZE{1'b0}}, rd};
      inflight    <= rd;
      stage_count <= stage_count + {1'b0, inflight} - {1'b0, pop};
      // A pop of an in-flight word with an empty stage consumes it without capture.
      if (pop) begin
        if (stage_count == 2'd2) begin
          head <= tail;
          if (inflight)
            tail <= read_data;
        end else if (stage_count == 2'd1 && inflight) begin
          head <= read_data;
        end
      end else if (inflight) begin
        if (stage_count == 2'd0)
          head <= read_data;
        else
          tail <= read_data;
      end
      if (cfg_ok) begin
        depth <= cfg_clamped;
        wptr  <= '0;
        rptr  <= '0;
      end else begin
        if (push)
          wptr <= wptr_next;
        if (rd)
          rptr <= rptr_next;
      end
    end
  end

`ifdef SRAM_FIFO_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      if (in_valid && !in_ready)
        overflow_err <= 1'b1;
      if (out_ready && !out_valid)
        underflow_err <= 1'b1;
      if (cfg_load && !cfg_ok)
        cfg_err <= 1'b1;
    end
  end
`else
  // Error flags are not built in this configuration.
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - randomized self-checking bench for sram_fifo_ctrl against a queue model.
module tb_sram_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data, write_data;
  logic [DW-1:0] read_data = '0;
  logic          cfg_load, full, empty, write_enable, read_enable;
  logic [AW:0]   cfg_depth, depth, count;
  logic [AW-1:0] write_address, read_address;
`ifdef SRAM_FIFO_ERR_EN
  logic          overflow_err, underflow_err, cfg_err;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_enable) mem[write_address] <= write_data;
    if (read_enable)  read_data <= mem[read_address];
  end

  sram_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_load(cfg_load), .cfg_depth(cfg_depth), .depth(depth), .count(count),
    .full(full), .empty(empty),
`ifdef SRAM_FIFO_ERR_EN
    .overflow_err(overflow_err), .underflow_err(underflow_err), .cfg_err(cfg_err),
`endif
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .read_enable(read_enable), .read_address(read_address), .read_data(read_data)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            t;
  } ent_t;

  ent_t q[$];
  int   passes = 0, checks = 0;
  int   cyc = 0, depth_m = 16, wr_n = 0, rd_n = 0, pushes = 0, pops = 0, maxcnt = 0;
  logic ov_m = 1'b0, un_m = 1'b0, cf_m = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int clampd(input int d);
    if (d < 2) return 2;
    if (d > 16) return 16;
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    depth_m = 16; wr_n = 0; rd_n = 0;
    ov_m = 1'b0; un_m = 1'b0; cf_m = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_depth"}, depth, 16);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_write_enable"}, write_enable, 0);
    chk({tag, "_write_address"}, write_address, 0);
    chk({tag, "_write_data"}, write_data, 0);
    chk({tag, "_read_enable"}, read_enable, 0);
    chk({tag, "_read_address"}, read_address, 0);
`ifdef SRAM_FIFO_ERR_EN
    chk({tag, "_errs"}, {overflow_err, underflow_err, cfg_err}, 3'b000);
`endif
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    int   cnt;
    logic ov, ep, epop, ecfg;
    @(negedge clk);
    cnt = q.size();
    if (cnt > maxcnt) maxcnt = cnt;
    ov = 1'b0;
    if (cnt > 0) ov = (q[0].t <= cyc - 2);
    ep   = in_valid && (cnt < depth_m);
    epop = ov && out_ready;
    ecfg = cfg_load && (cnt == 0) && !ep;
    chk("count", count, cnt);
    chk("in_ready", in_ready, cnt < depth_m);
    chk("full", full, cnt == depth_m);
    chk("empty", empty, cnt == 0);
    chk("depth", depth, depth_m);
    chk("out_valid", out_valid, ov);
    if (ov) chk("out_data", out_data, q[0].data);
    chk("write_enable", write_enable, ep);
    if (ep) begin
      chk("write_address", write_address, wr_n % depth_m);
      chk("write_data", write_data, in_data);
    end
    if (read_enable === 1'b1) begin
      chk("read_address", read_address, rd_n % depth_m);
      rd_n++;
    end
`ifdef SRAM_FIFO_ERR_EN
    chk("errs", {overflow_err, underflow_err, cfg_err}, {ov_m, un_m, cf_m});
    if (in_valid && !(cnt < depth_m)) ov_m = 1'b1;
    if (out_ready && !ov) un_m = 1'b1;
    if (cfg_load && !ecfg) cf_m = 1'b1;
`endif
    @(posedge clk);
    if (epop) begin void'(q.pop_front()); pops++; end
    if (ep) begin q.push_back('{in_data, cyc}); wr_n++; pushes++; end
    if (ecfg) begin depth_m = clampd(int'(cfg_depth)); wr_n = 0; rd_n = 0; end
    cyc++;
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) step();
    step();
    chk("drain_count", count, 0);
    out_ready = 1'b0;
  endtask

  task automatic load_depth(input int d);
    cfg_depth = d[AW:0]; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cfg_load = 1'b0; cfg_depth = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    in_valid = 1'b1; in_data = 32'hA5;
    step();
    in_valid = 1'b0;
    chk("a5_read_enable", read_enable, 1);
    chk("a5_read_address", read_address, 0);
    step();
    chk("a5_out_valid", out_valid, 1);
    chk("a5_out_data", out_data, 32'hA5);
    drain();

    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin in_data = $urandom; step(); end
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 16);
    in_data = $urandom;
    step();
`ifdef SRAM_FIFO_ERR_EN
    chk("overflow_err", overflow_err, 1);
`endif
    drain();

    load_depth(5);
    chk("depth5", depth, 5);
    p0 = pushes; maxcnt = 0;
    for (int i = 0; i < 300 && pushes - p0 < 20; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0) && (pushes - p0 < 20);
      in_data   = $urandom;
      out_ready = $urandom_range(0, 1);
      step();
    end
    chk("stream20_pushed", pushes - p0, 20);
    chk("stream20_maxcnt_le5", maxcnt <= 5, 1);
    drain();

    load_depth(16);
    p0 = pops;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin in_data = $urandom; step(); end
    chk("steady_pops", pops - p0, 30);
    chk("steady_count", count, 2);
    drain();

    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = $urandom; step(); end
    in_valid = 1'b0;
    load_depth(7);
    chk("cfg_busy_depth", depth, 16);
`ifdef SRAM_FIFO_ERR_EN
    chk("cfg_err", cfg_err, 1);
`endif
    drain();
    load_depth(1);
    chk("cfg_min_depth", depth, 2);
    load_depth(31);
    chk("cfg_max_depth", depth, 16);

    load_depth(5);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = $urandom; out_ready = $urandom_range(0, 1);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
